// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each pipeline stage adds one WIDTH/STAGES-bit slice.
// Latency: STAGES cycles from acceptance to out_valid. Throughput: one result per cycle.
// Backpressure: each stage advances when its successor is empty or advancing; in_ready is low in reset.
module pipe_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int SW   = WIDTH / STAGES;
    localparam int NG   = SW / GROUP;
    localparam int LAST = STAGES - 1;

    // Operands travel with the pipe; slices at or above the current stage are still unprocessed.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cmsb;
    } stg_t;

    stg_t              stg_q   [STAGES];
    stg_t              stg_d   [STAGES];
    stg_t              stg_sum [STAGES];
    stg_t              in_stg;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] ld;
    logic [STAGES:0]   vchain;
    logic              zero_q;
    logic              zero_d;

    // Carry into bit n of a group, expanded as a two-level lookahead term.
    function automatic logic la_carry(input logic [GROUP-1:0] g, input logic [GROUP-1:0] p,
                                      input logic ci, input int n);
        logic r;
        logic t;
        r = ci;
        for (int i = 0; i < n; i++) r = r & p[i];
        for (int i = 0; i < n; i++) begin
            t = g[i];
            for (int m = i + 1; m < n; m++) t = t & p[m];
            r = r | t;
        end
        return r;
    endfunction

    always_comb begin
        logic nxt_rdy;
        nxt_rdy = out_ready;
        rdy     = '0;
        for (int k = LAST; k >= 0; k--) begin
            rdy[k]  = !vld_q[k] || nxt_rdy;
            nxt_rdy = rdy[k];
        end
    end

    assign vchain = {vld_q, in_valid};

    always_comb begin
        ld    = '0;
        vld_d = vld_q;
        for (int k = 0; k < STAGES; k++) begin
            ld[k]    = rdy[k] && vchain[k];
            vld_d[k] = rdy[k] ? vchain[k] : vld_q[k];
        end
    end

    // Subtraction folds into a + ~b + 1; cin is irrelevant then.
    always_comb begin
        in_stg   = '0;
        in_stg.a = a;
        in_stg.b = sub ? ~b : b;
        in_stg.c = sub | cin;
    end

    always_comb begin
        stg_t             src;
        logic             c;
        logic [GROUP-1:0] gv;
        logic [GROUP-1:0] pv;
        logic [GROUP-1:0] xv;
        int               base;
        for (int k = 0; k < STAGES; k++) begin
            src        = (k == 0) ? in_stg : stg_q[(k == 0) ? 0 : k - 1];
            stg_sum[k] = src;
            c          = src.c;
            for (int g = 0; g < NG; g++) begin
                base = k * SW + g * GROUP;
                gv   = src.a[base +: GROUP] & src.b[base +: GROUP];
                pv   = src.a[base +: GROUP] | src.b[base +: GROUP];
                xv   = src.a[base +: GROUP] ^ src.b[base +: GROUP];
                for (int j = 0; j < GROUP; j++) begin
                    stg_sum[k].s[base + j] = xv[j] ^ la_carry(gv, pv, c, j);
                    if (base + j == WIDTH - 1) stg_sum[k].cmsb = la_carry(gv, pv, c, j);
                end
                c = la_carry(gv, pv, c, GROUP);
            end
            stg_sum[k].c = c;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stg_d[k] = ld[k] ? stg_sum[k] : stg_q[k];
        end
        zero_d = ld[LAST] ? (stg_sum[LAST].s == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
        end else begin
            vld_q  <= vld_d;
            zero_q <= zero_d;
            for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
        end
    end

    assign in_ready  = rst_n & rdy[0];
    assign out_valid = vld_q[LAST];
    assign sum       = stg_q[LAST].s;
    assign cout      = stg_q[LAST].c;
    assign overflow  = stg_q[LAST].cmsb ^ stg_q[LAST].c;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipe_cla_adder.sv
// Directed bench for pipe_cla_adder at WIDTH=32, GROUP=4, STAGES=2.
module tb_pipe_cla_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    pipe_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Returns {cout, overflow, zero, sum}.
    function automatic logic [34:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic sb);
        logic [31:0] yy;
        logic [32:0] r;
        logic        ovf;
        yy  = sb ? ~y : y;
        r   = {1'b0, x} + {1'b0, yy} + {32'b0, (sb ? 1'b1 : ci)};
        ovf = (x[31] == yy[31]) && (r[31] != x[31]);
        return {r[32], ovf, (r[31:0] == 32'd0), r[31:0]};
    endfunction

    // Called just after a falling edge; leaves just after the falling edge where the result shows.
    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic sb, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
        #1 chk1({tag, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom;
        #1 chk1({tag, "_vld_early"}, out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk1({tag, "_vld"}, out_valid, 1'b1);
        chk32({tag, "_sum"}, sum, es);
        chk1({tag, "_cout"}, cout, ec);
        chk1({tag, "_ovf"}, overflow, eo);
        chk1({tag, "_zero"}, zero, ez);
    endtask

    logic [34:0] q[$];
    logic [34:0] front;
    logic [31:0] held;
    logic        stall_prev;
    int          pushed;
    int          popped;
    int          cyc;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_sum", sum, 32'h0);
        chk1("rst_cout", cout, 1'b0);
        chk1("rst_ovf", overflow, 1'b0);
        chk1("rst_zero", zero, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk1("first_in_ready", in_ready, 1'b1);

        do_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        do_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        do_op("add_cin",  32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        do_op("sub_neg",  32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        do_op("sub_ovf",  32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

        // Stream 8 sets, stalling the output for cycles 3..7.
        pushed = 0; popped = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        while (popped < 8 && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (pushed < 8);
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            #1;
            chk1("stream_in_ready", in_ready, !((pushed - popped) == 2 && !out_ready));
            if (stall_prev) begin
                chk1("stall_hold_vld", out_valid, 1'b1);
                chk32("stall_hold_sum", sum, held);
            end
            if (out_valid) begin
                chk1("stream_no_dup", q.size() != 0, 1'b1);
                front = (q.size() != 0) ? q[0] : 35'h0;
                chk32("stream_sum", sum, front[31:0]);
                chk1("stream_cout", cout, front[34]);
                chk1("stream_ovf", overflow, front[33]);
                chk1("stream_zero", zero, front[32]);
                if (out_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_op(a, b, cin, sub));
                pushed++;
            end
            stall_prev = out_valid && !out_ready;
            held = sum;
            cyc++;
        end
        chk32("stream_popped", 32'(popped), 32'd8);
        chk32("stream_left", 32'(q.size()), 32'd0);

        // Two operations in flight, then an asynchronous reset between edges.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'h12345678; b = 32'h11111111; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        a = 32'h0F0F0F0F; b = 32'h01010101;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk1("inflight_vld", out_valid, 1'b1);
        chk32("inflight_sum", sum, 32'h23456789);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk32("midrst_sum", sum, 32'h0);
        chk1("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1 chk1("rel_in_ready", in_ready, 1'b1);
        do_op("post_rst", 32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk1("no_stale", out_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter GROUP, default 4: carry-lookahead group width in bits.
REQ-003 Parameter STAGES, default 2: number of pipeline register stages; legal range 1..WIDTH/GROUP.
REQ-004 WIDTH SHALL be divisible by GROUP*STAGES; any other combination is illegal and SHALL NOT be supported.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  an operand set is presented.
REQ-008 in_ready  output  1  the block accepts the operand set this cycle.
REQ-009 a, b  input  WIDTH  operands.
REQ-010 cin  input  1  carry-in, used in add mode only.
REQ-011 sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of the MSB.
REQ-016 overflow  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  asserted when sum is all zeros.

Function
REQ-018 Add mode SHALL compute {cout,sum} = a + b + cin; subtract mode SHALL compute a + ~b + 1, and cin SHALL be ignored.
REQ-019 The datapath SHALL be split into STAGES slices of WIDTH/STAGES bits each.
- Slice k SHALL be added in pipeline stage k, least-significant slice first.
- Within a slice, addition SHALL use GROUP-bit carry-lookahead groups (generate = a&b, propagate = a|b) with group carries rippled between groups.
REQ-020 The carry between slices SHALL be registered.
- Unprocessed upper operand bits and completed lower sum bits SHALL be carried forward in the stage registers with the carry.
REQ-021 Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
- Once out_valid is asserted, it and all result outputs SHALL remain stable until accepted.
REQ-022 Latency SHALL be exactly STAGES cycles from input acceptance to out_valid, provided no stall occurs.
REQ-023 Throughput SHALL be one result per cycle while out_ready stays 1.
REQ-024 Each stage SHALL advance when its successor is empty or advancing.
- in_ready = (stage 0 empty) OR (stage 0 advancing), so back-pressure SHALL ripple one stage per cycle and no bubble is required.
REQ-025 When the pipeline is full and out_ready = 0, in_ready SHALL be 0 and no stage register SHALL change.
REQ-026 If accept and emit occur in the same cycle, both SHALL take effect, and results SHALL leave in input order.
REQ-027 overflow SHALL equal the carry into the MSB XOR cout.
- In subtract mode, cout = 1 SHALL mean no borrow.
REQ-028 zero SHALL be computed from the final sum; if it is registered, it SHALL be registered alongside sum.
REQ-029 Inputs SHALL be ignored when in_valid = 0.
- Operand and mode values SHALL be sampled only on an accepting edge.

Reset
REQ-030 While rst_n = 0, all stage valid flags, out_valid, sum, cout, overflow and zero SHALL be 0 immediately, regardless of clk.
REQ-031 During reset, in_ready SHALL be 0.
REQ-032 In-flight operations SHALL be discarded when rst_n is asserted mid-operation; no partial result SHALL ever appear.
REQ-033 The first input SHALL be accepted on the first rising edge after rst_n deasserts, giving in_ready = 1 in that cycle.

Verification (WIDTH=32, GROUP=4, STAGES=2)
REQ-034 Add case: a=FFFFFFFF, b=00000001, cin=0, sub=0 -> after 2 cycles sum=00000000, cout=1, overflow=0, zero=1.
REQ-035 Add-overflow case: a=7FFFFFFF, b=00000001, sub=0 -> sum=80000000, cout=0, overflow=1, zero=0; the carry crosses the slice boundary.
REQ-036 Subtract cases, both with cin=1 to prove it is ignored:
- a=00000005, b=00000007, sub=1 -> sum=FFFFFFFE, cout=0, overflow=0.
- a=80000000, b=00000001, sub=1 -> sum=7FFFFFFF, cout=1, overflow=1.
REQ-037 Stream/stall case: stream 8 random operand sets back-to-back, then hold out_ready=0 for 5 cycles.
- Required: in_ready drops once 2 sets are held, outputs stay stable, and all 8 results emerge in order versus the reference model.
- No loss and no duplication.
REQ-038 Reset case: assert rst_n=0 asynchronously (between clock edges) with 2 operations in flight.
- Required: out_valid=0 and sum=0 at once; after release, no stale result ever appears.
